// File: rtl/sram_req_queue.sv
// Request queue in front of the SRAM controller: buffers client commands, issues them in order
// and returns read data as a registered response pulse. Define SRAM_REQ_STATS_EN for issue counters.
module sram_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r
`ifdef SRAM_REQ_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic              r_rw_q   [DEPTH];
    logic [ADDR_W-1:0] r_addr_q [DEPTH];
    logic [DATA_W-1:0] r_data_q [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [2:0]        r_rd_pipe;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rd_issue;
    logic w_wr_issue;

    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Full blocks pushes even when a pop happens in the same cycle.
    assign w_push     = req_valid & ~w_full;
    assign w_pop      = ~w_empty & ready;
    assign w_rd_issue = w_pop & r_rw_q[r_rd_ptr];
    assign w_wr_issue = w_pop & ~r_rw_q[r_rd_ptr];

    assign req_ready = ~w_full;
    assign mem       = ~w_empty;
    assign rw        = r_rw_q[r_rd_ptr];
    assign addr      = r_addr_q[r_rd_ptr];
    assign data_f2s  = r_data_q[r_rd_ptr];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rw_q[i]   <= 1'b0;
                r_addr_q[i] <= '0;
                r_data_q[i] <= '0;
            end
        end else if (w_push) begin
            r_rw_q[r_wr_ptr]   <= req_rw;
            r_addr_q[r_wr_ptr] <= req_addr;
            r_data_q[r_wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read issued in cycle T reaches stage 2 in T+3, when the controller holds its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pipe   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[1:0], w_rd_issue};
            if (r_rd_pipe[2]) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= data_s2f_r;
            end else begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SRAM_REQ_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_issue) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_wr_issue) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_sram_req_queue.sv
// Bench for sram_req_queue: queue-level reference model checked every cycle, a small SRAM
// controller model driving ready/data_s2f_r, and directed scenarios with literal expectations.
module tb_sram_req_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;
`ifdef SRAM_REQ_STATS_EN
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;
`endif

    sram_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
        .ready(ready), .data_s2f_r(data_s2f_r)
`ifdef SRAM_REQ_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;
    typedef struct {
        int                due;
        logic [DATA_W-1:0] d;
    } rsp_t;
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    // reference model state (written only by the posedge process)
    cmd_t              q[$];
    rsp_t              rq[$];
    cmd_t              e;
    logic [DATA_W-1:0] ref_sram [256];
    logic [DATA_W-1:0] ctl_sram [256];
    int                pend_cyc [8];
    logic [DATA_W-1:0] pend_d   [8];
    logic              m_rsp_v = 1'b0;
    logic [DATA_W-1:0] m_rsp_d = '0;
    logic [15:0]       m_rd = '0;
    logic [15:0]       m_wr = '0;
    int                cyc = 0;
    int                last_rd_issue = -100;
    int                n_rd_issue = 0;
    bit                chk_en = 1'b0;
    bit                pre_done = 1'b0;
    bit                push_ok;
    bit                pop_ok;

    // controller model inputs
    logic              ctl_hold;
    logic              tog = 1'b0;

    // checker state (written only by the compare process)
    int                n_checks = 0;
    int                n_err = 0;
    int                n_rsp = 0;
    int                lit_rd = 0;
    logic [DATA_W-1:0] rsp_log[$];
    int                rsp_cyc_log[$];

    lit_t              lit_q[$];

    always @(posedge clk) begin
        if (!pre_done) begin
            for (int i = 0; i < 256; i++) begin
                ref_sram[i] = '0;
                ctl_sram[i] = '0;
            end
            ref_sram[1] = 16'h1111; ctl_sram[1] = 16'h1111;
            ref_sram[2] = 16'h2222; ctl_sram[2] = 16'h2222;
            ref_sram[3] = 16'h3333; ctl_sram[3] = 16'h3333;
            pre_done = 1'b1;
        end
        // controller: acts on what the DUT presents
        if (reset) begin
            for (int i = 0; i < 8; i++) pend_cyc[i] = -1;
        end else if (mem && ready) begin
            if (rw) begin
                pend_cyc[(cyc + 3) % 8] = cyc + 3;
                pend_d[(cyc + 3) % 8]   = ctl_sram[addr[7:0]];
            end else begin
                ctl_sram[addr[7:0]] = data_f2s;
            end
        end
        // reference model
        if (reset) begin
            q.delete();
            rq.delete();
            m_rsp_v = 1'b0;
            m_rsp_d = '0;
            m_rd    = '0;
            m_wr    = '0;
            chk_en  = 1'b1;
        end else begin
            pop_ok  = (q.size() > 0) && ready;
            push_ok = req_valid && (q.size() < DEPTH);
            if (pop_ok) begin
                e = q.pop_front();
                if (e.rw) begin
                    rq.push_back('{cyc + 4, ref_sram[e.addr[7:0]]});
                    m_rd          = m_rd + 16'd1;
                    last_rd_issue = cyc;
                    n_rd_issue++;
                end else begin
                    ref_sram[e.addr[7:0]] = e.data;
                    m_wr = m_wr + 16'd1;
                end
            end
            if (push_ok) q.push_back('{req_rw, req_addr, req_wdata});
        end
        cyc++;
        if (!reset) begin
            m_rsp_v = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_rsp_v = 1'b1;
                m_rsp_d = rq[0].d;
                void'(rq.pop_front());
            end
        end
    end

    // controller drive: at most one issue per two cycles, read data valid only in issue+3
    always @(negedge clk) begin
        tog        = ~tog;
        ready      = ~ctl_hold & tog;
        data_s2f_r = (pend_cyc[cyc % 8] == cyc) ? pend_d[cyc % 8] : 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            chk("mem", 32'(mem), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("head_rw", 32'(rw), 32'(q[0].rw));
                chk("head_addr", 32'(addr), 32'(q[0].addr));
                chk("head_data", 32'(data_f2s), 32'(q[0].data));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
`ifdef SRAM_REQ_STATS_EN
            chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
            chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
`endif
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                rsp_log.push_back(rsp_data);
                rsp_cyc_log.push_back(cyc);
            end
        end
        while (lit_rd < lit_q.size()) begin
            chk(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
            lit_rd++;
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_q.push_back('{name, act, exp});
    endtask

    task automatic send(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic acc;
        bit   done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_rw    = r;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) done = 1'b1;
        end
        if (!done) lit("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int target, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_rsp >= target) got = 1'b1;
        end
        if (!got) lit(name, 32'(n_rsp), 32'(target));
    endtask

    int base;
    int base_iss;
    bit seen;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        ctl_hold  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lit("rst_mem", 32'(mem), 32'd0);
        lit("rst_req_ready", 32'(req_ready), 32'd1);
        lit("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        lit("rst_rsp_data", 32'(rsp_data), 32'd0);
        lit("rst_rw", 32'(rw), 32'd0);
        lit("rst_addr", 32'(addr), 32'd0);
        lit("rst_data_f2s", 32'(data_f2s), 32'd0);

        // write then read the same address
        base = n_rsp;
        send(1'b0, 18'h00012, 16'hA5A5);
        send(1'b1, 18'h00012, 16'h0000);
        req_valid = 1'b0;
        wait_rsp(base + 1, "wr_rd_timeout");
        if (rsp_log.size() > base) begin
            lit("wr_rd_data", 32'(rsp_log[base]), 32'h0000A5A5);
            lit("wr_rd_latency", 32'(rsp_cyc_log[base] - last_rd_issue), 32'd4);
        end
        repeat (10) @(negedge clk);
        lit("wr_no_rsp", 32'(n_rsp - base), 32'd1);
`ifdef SRAM_REQ_STATS_EN
        lit("stats_wr1", 32'(wr_cnt), 32'd1);
        lit("stats_rd1", 32'(rd_cnt), 32'd1);
`endif

        // backpressure: controller stalled, fill the queue
        ctl_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) send(1'b0, 18'(20 + i), 16'(16'hB000 + i));
        lit("bp_full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 18'd24;
        req_wdata = 16'hB004;
        repeat (3) @(negedge clk);
        lit("bp_5th_blocked", 32'(req_ready), 32'd0);
        lit("bp_head_addr", 32'(addr), 32'd20);
        ctl_hold = 1'b0;
        send(1'b0, 18'd24, 16'hB004);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        lit("bp_drained", 32'(mem), 32'd0);

        // back-to-back reads of preloaded words
        base = n_rsp;
        send(1'b1, 18'd1, 16'h0);
        send(1'b1, 18'd2, 16'h0);
        send(1'b1, 18'd3, 16'h0);
        req_valid = 1'b0;
        wait_rsp(base + 3, "b2b_timeout");
        if (rsp_log.size() >= base + 3) begin
            lit("b2b_rsp0", 32'(rsp_log[base]),     32'h00001111);
            lit("b2b_rsp1", 32'(rsp_log[base + 1]), 32'h00002222);
            lit("b2b_rsp2", 32'(rsp_log[base + 2]), 32'h00003333);
        end

        // mixed stream with pointer wrap
        base = n_rsp;
        for (int k = 0; k < 5; k++) begin
            send(1'b0, 18'(4 + k), 16'(16'hC000 + k));
            send(1'b1, 18'(4 + k), 16'h0);
        end
        req_valid = 1'b0;
        wait_rsp(base + 5, "mix_timeout");
        if (rsp_log.size() >= base + 5) begin
            lit("mix_rsp0", 32'(rsp_log[base]),     32'h0000C000);
            lit("mix_rsp2", 32'(rsp_log[base + 2]), 32'h0000C002);
            lit("mix_rsp4", 32'(rsp_log[base + 4]), 32'h0000C004);
        end
        repeat (10) @(negedge clk);

        // reset in the cycle after a read issues
        base     = n_rsp;
        base_iss = n_rd_issue;
        send(1'b1, 18'd1, 16'h0);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (n_rd_issue > base_iss) seen = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        if (!seen) lit("rst_rd_issue_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit("midrst_mem", 32'(mem), 32'd0);
        lit("midrst_req_ready", 32'(req_ready), 32'd1);
        lit("midrst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (10) @(negedge clk);
        lit("midrst_no_rsp", 32'(n_rsp - base), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
